hash_out_serializer: RTL and testbench
======================================

Name: hash_out_serializer

Overview:
- Output stage of the miner; sits directly downstream of the final BMW stage.
- Buffers 256-bit final hashes in a circular FIFO and serializes each hash into 32-bit words for the AXI read-register path.
- Provides back-pressure to the BMW stage, a sticky overflow flag, and a free-running accepted-hash counter used for hashrate measurement.

Parameters:
- DECODE_WIDTH, 256, hash width in bits.
- AXI_DATA_WIDTH, 32, output word width. DECODE_WIDTH must be an integer multiple of it.
- FIFO_DEPTH, 16, number of hash entries. Must be a power of two, at least 2.
- WORDS (localparam), DECODE_WIDTH/AXI_DATA_WIDTH = 8, words per hash.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous soft flush; same effect as rst except hash_count is kept.
- din  in  DECODE_WIDTH  final hash from the BMW stage.
- din_wr_en  in  1  write strobe; din is sampled on the same edge.
- din_full  out  1  FIFO full; the producer must not assert din_wr_en while this is high.
- rd_req  in  1  pop-one-word request from the AXI read logic.
- rd_data  out  AXI_DATA_WIDTH  serialized word, registered.
- rd_vld  out  1  one-cycle pulse; rd_data is valid.
- rd_last  out  1  high together with rd_vld on word WORDS-1 of a hash.
- level  out  $clog2(FIFO_DEPTH)+1  number of complete hashes stored. The partially read head entry counts until its last word is read.
- overflow  out  1  sticky; a write was attempted while full.
- hash_count  out  32  count of accepted writes; wraps modulo 2^32.

Behaviour:
- Reset values (rst): all outputs 0; wr_ptr=0, rd_ptr=0, word_idx=0; state EMPTY.
- clr: same as reset, except hash_count holds its value. rst takes priority over clr.
- Storage: FIFO_DEPTH x DECODE_WIDTH array, plus wrap-around pointers of width $clog2(FIFO_DEPTH).
  - level is a registered counter.
  - din_full = (level == FIFO_DEPTH), derived from the registered level.
- Write:
  - din_wr_en && !din_full: store din at wr_ptr, increment wr_ptr (wraps to 0 after FIFO_DEPTH-1), increment hash_count.
  - din_wr_en && din_full: data is dropped; overflow is set to 1; pointers, level and hash_count are unchanged. This holds even if the last word is popped in the same cycle.
- Word order: word k = entry[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], with k = word_idx. Least-significant word goes out first.
- FSM:
  - EMPTY: level==0. rd_req is ignored: rd_vld stays 0, rd_data holds its last value. Moves to AVAIL when level becomes nonzero.
  - AVAIL: level>0. On rd_req:
    - rd_data <= word word_idx of entry[rd_ptr]; rd_vld=1 on the next cycle (latency 1).
    - word_idx increments.
    - On word_idx==WORDS-1: rd_last=1, word_idx<=0, rd_ptr increments, level decrements, and the state moves to EMPTY if the new level is 0.
- rd_req held high for consecutive cycles gives one word per cycle, with no bubbles across hash boundaries.
- Simultaneous write and last-word pop (not full): level is unchanged, both pointers advance.
- Simultaneous write into an empty FIFO with rd_req: no word is produced that cycle. The rd_req is ignored, and the first pop is possible on the next cycle.
- A mid-hash flush via clr discards the partial hash; the next read starts at word 0 of the next written hash.
- rd_vld and rd_last are never asserted without a preceding accepted rd_req.

Test Plan:
- Single hash: write din=0x0706...01_00 pattern (word k = 32'h1000_0000+k), then rd_req for 8 cycles -> rd_data = 0x10000000..0x10000007 in order, rd_vld each cycle one cycle after the request, rd_last only on the 8th word, level 1->0, hash_count=1.
- Fill: write 16 distinct hashes -> din_full=1, level=16. A 17th write -> overflow=1, hash_count=16, and the stored data is intact. Read all 128 words -> data is in FIFO order and the pointers wrap correctly.
- Empty read: rd_req for 5 cycles after reset -> rd_vld=0, rd_data=0, no state change.
- Concurrent: level=3 with word_idx=7; write and rd_req in the same cycle -> level stays 3, rd_last=1, and the next read returns word 0 of the next entry.
- Mid-hash clr: read 3 words, pulse clr -> level=0, overflow=0, hash_count is kept. Write a new hash and read -> the first word is word 0 of the new hash.
- Counter wrap: force hash_count to 0xFFFFFFFF, write one hash -> hash_count=0. Assert rst mid-stream -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/hash_out_serializer.sv
// rtl/hash_out_serializer.sv - buffers final hashes in a circular FIFO and serializes them into AXI-width words
module hash_out_serializer #(
    parameter int DECODE_WIDTH   = 256,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [DECODE_WIDTH-1:0]       din,
    input  logic                          din_wr_en,
    output logic                          din_full,
    input  logic                          rd_req,
    output logic [AXI_DATA_WIDTH-1:0]     rd_data,
    output logic                          rd_vld,
    output logic                          rd_last,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [31:0]                   hash_count
);
    localparam int WORDS = DECODE_WIDTH / AXI_DATA_WIDTH;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {EMPTY, AVAIL} state_t;

    logic [DECODE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [IW-1:0]           word_idx;
    state_t                  state, state_n;
    logic                    wr_acc, pop, pop_last;
    logic [LW-1:0]           level_n;
    logic [DECODE_WIDTH-1:0] head;

    assign din_full = (level == LW'(FIFO_DEPTH));
    assign head     = mem[rd_ptr];

    always_comb begin
        wr_acc   = din_wr_en && !din_full;
        pop      = (state == AVAIL) && rd_req;
        pop_last = pop && (word_idx == IW'(WORDS - 1));
        level_n  = level;
        if (wr_acc && !pop_last)
            level_n = level + LW'(1);
        else if (!wr_acc && pop_last)
            level_n = level - LW'(1);
        state_n = (level_n != '0) ? AVAIL : EMPTY;
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst && !clr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_idx   <= '0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            overflow   <= 1'b0;
            hash_count <= '0;
        end else if (clr) begin
            state    <= EMPTY;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            rd_data  <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            level   <= level_n;
            rd_vld  <= pop;
            rd_last <= pop_last;
            if (pop) begin
                rd_data  <= head[word_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                word_idx <= pop_last ? '0 : word_idx + IW'(1);
            end
            if (pop_last)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_acc) begin
                wr_ptr     <= wr_ptr + PW'(1);
                hash_count <= hash_count + 32'd1;
            end
            if (din_wr_en && din_full)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hash_out_serializer.sv
// tb/tb_hash_out_serializer.sv - scoreboard bench for hash_out_serializer
module tb_hash_out_serializer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [255:0] din = '0;
    logic         din_wr_en = 1'b0;
    logic         din_full;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_data;
    logic         rd_vld;
    logic         rd_last;
    logic [4:0]   level;
    logic         overflow;
    logic [31:0]  hash_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t          exp_q[$];
    logic [255:0]  mq[$];
    int            m_widx = 0;
    logic [31:0]   m_count = 0;
    logic          m_ovf = 0;

    hash_out_serializer dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_wr_en(din_wr_en),
        .din_full(din_full), .rd_req(rd_req), .rd_data(rd_data), .rd_vld(rd_vld),
        .rd_last(rd_last), .level(level), .overflow(overflow), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] mk_hash(input logic [31:0] base);
        logic [255:0] h;
        for (int k = 0; k < 8; k++) h[k*32 +: 32] = base + 32'(k);
        return h;
    endfunction

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_rd_vld: got data %0h with no pending request", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e.data));
                chk("rd_last", 64'(rd_last), 64'(e.last));
            end
        end else if (rd_last) begin
            chk("rd_last_without_vld", 64'(rd_last), 64'd0);
        end
    end

    // One clock of stimulus; the model is updated from pre-edge state like the DUT.
    task automatic cycle(input bit wr, input logic [255:0] d, input bit rq,
                         input bit c = 1'b0, input bit r = 1'b0);
        bit pop, acc;
        din = d; din_wr_en = wr; rd_req = rq; clr = c; rst = r;
        pop = !r && !c && rq && (mq.size() > 0);
        acc = !r && !c && wr && (mq.size() < 16);
        if (pop) begin
            exp_t e;
            e.data = mq[0][m_widx*32 +: 32];
            e.last = (m_widx == 7);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        din_wr_en = 1'b0; rd_req = 1'b0; clr = 1'b0; rst = 1'b0;
        if (r || c) begin
            mq.delete(); m_widx = 0; m_ovf = 0;
            if (r) m_count = 0;
        end else begin
            if (wr && mq.size() >= 16) m_ovf = 1;
            if (pop) begin
                if (m_widx == 7) begin
                    void'(mq.pop_front());
                    m_widx = 0;
                end else m_widx++;
            end
            if (acc) begin
                mq.push_back(d);
                m_count++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && mq.size() > 0; i++) cycle(0, '0, 1);
        cycle(0, '0, 0);
    endtask

    initial begin
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        chk("reset_rd_data",    64'(rd_data), 0);
        chk("reset_rd_vld",     64'(rd_vld), 0);
        chk("reset_rd_last",    64'(rd_last), 0);
        chk("reset_level",      64'(level), 0);
        chk("reset_overflow",   64'(overflow), 0);
        chk("reset_hash_count", 64'(hash_count), 0);
        chk("reset_din_full",   64'(din_full), 0);

        for (int i = 0; i < 5; i++) cycle(0, '0, 1);
        cycle(0, '0, 0);
        chk("empty_rd_data", 64'(rd_data), 0);
        chk("empty_level",   64'(level), 0);

        cycle(1, mk_hash(32'h1000_0000), 0);
        chk("single_level_1", 64'(level), 1);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1);
        cycle(0, '0, 0);
        chk("single_level_0", 64'(level), 0);
        chk("single_hash_count", 64'(hash_count), 1);

        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, mk_hash(32'hA000_0000 + 32'(i*16)), 0);
        chk("fill_din_full", 64'(din_full), 1);
        chk("fill_level",    64'(level), 16);
        cycle(1, mk_hash(32'hDEAD_0000), 0);
        chk("fill_overflow",   64'(overflow), 1);
        chk("fill_hash_count", 64'(hash_count), 16);
        chk("fill_level_kept", 64'(level), 16);
        drain();
        chk("fill_drained_level", 64'(level), 0);
        chk("fill_drained_full",  64'(din_full), 0);

        for (int i = 0; i < 3; i++) cycle(1, mk_hash(32'hB000_0000 + 32'(i*16)), 0);
        for (int i = 0; i < 7; i++) cycle(0, '0, 1);
        cycle(1, mk_hash(32'hB000_0030), 1);
        chk("concurrent_level", 64'(level), 3);
        drain();

        cycle(1, mk_hash(32'hC000_0000), 0);
        cycle(1, mk_hash(32'hC000_0010), 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1);
        cycle(0, '0, 0);
        cycle(0, '0, 0, 1, 0);
        chk("clr_level",      64'(level), 0);
        chk("clr_overflow",   64'(overflow), 0);
        chk("clr_hash_count", 64'(hash_count), 64'(m_count));
        cycle(1, mk_hash(32'hE000_0000), 0);
        drain();

        force dut.hash_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hash_count;
        m_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap_forced", 64'(hash_count), 64'hFFFF_FFFF);
        cycle(1, mk_hash(32'hF000_0000), 0);
        chk("wrap_hash_count", 64'(hash_count), 0);
        cycle(1, mk_hash(32'hF000_0010), 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1);
        cycle(1, mk_hash(32'hF000_0020), 1, 0, 1);
        chk("rst_mid_rd_data",    64'(rd_data), 0);
        chk("rst_mid_rd_vld",     64'(rd_vld), 0);
        chk("rst_mid_rd_last",    64'(rd_last), 0);
        chk("rst_mid_level",      64'(level), 0);
        chk("rst_mid_hash_count", 64'(hash_count), 0);
        chk("rst_mid_din_full",   64'(din_full), 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
